// File: rtl/tx_enc_8b10b.sv
// 8b/10b transmit encoder: byte/K in, 10-bit code group out, running disparity tracked across symbols.
// Optional TX_ENC_IDLE_INSERT_EN: empty output slots are filled with IDLE_K instead of dropping dout_valid.
module tx_enc_8b10b #(
  parameter logic [7:0] IDLE_K = 8'hBC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       k_in,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [9:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       rd_out,
  output logic       code_err
);

  function automatic logic k_legal(input logic [7:0] b);
    logic ok;
    case (b)
      8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
      8'hF7, 8'hFB, 8'hFD, 8'hFE: ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Table entries are {complement-at-RD+, code at RD-}, code written a..i with a in the MSB.
  function automatic logic [6:0] tab6(input logic [4:0] x, input logic k);
    logic [6:0] t;
    if (k && (x == 5'd28)) begin
      t = {1'b1, 6'b001111};
    end else begin
      case (x)
        5'd0:  t = {1'b1, 6'b100111};
        5'd1:  t = {1'b1, 6'b011101};
        5'd2:  t = {1'b1, 6'b101101};
        5'd3:  t = {1'b0, 6'b110001};
        5'd4:  t = {1'b1, 6'b110101};
        5'd5:  t = {1'b0, 6'b101001};
        5'd6:  t = {1'b0, 6'b011001};
        5'd7:  t = {1'b1, 6'b111000};
        5'd8:  t = {1'b1, 6'b111001};
        5'd9:  t = {1'b0, 6'b100101};
        5'd10: t = {1'b0, 6'b010101};
        5'd11: t = {1'b0, 6'b110100};
        5'd12: t = {1'b0, 6'b001101};
        5'd13: t = {1'b0, 6'b101100};
        5'd14: t = {1'b0, 6'b011100};
        5'd15: t = {1'b1, 6'b010111};
        5'd16: t = {1'b1, 6'b011011};
        5'd17: t = {1'b0, 6'b100011};
        5'd18: t = {1'b0, 6'b010011};
        5'd19: t = {1'b0, 6'b110010};
        5'd20: t = {1'b0, 6'b001011};
        5'd21: t = {1'b0, 6'b101010};
        5'd22: t = {1'b0, 6'b011010};
        5'd23: t = {1'b1, 6'b111010};
        5'd24: t = {1'b1, 6'b110011};
        5'd25: t = {1'b0, 6'b100110};
        5'd26: t = {1'b0, 6'b010110};
        5'd27: t = {1'b1, 6'b110110};
        5'd28: t = {1'b0, 6'b001110};
        5'd29: t = {1'b1, 6'b101110};
        5'd30: t = {1'b1, 6'b011110};
        5'd31: t = {1'b1, 6'b101011};
        default: t = 7'd0;
      endcase
    end
    return t;
  endfunction

  function automatic logic [4:0] tab4(input logic [2:0] y, input logic k, input logic a7);
    logic [4:0] t;
    if (k) begin
      case (y)
        3'd0: t = {1'b1, 4'b1011};
        3'd1: t = {1'b1, 4'b0110};
        3'd2: t = {1'b1, 4'b1010};
        3'd3: t = {1'b1, 4'b1100};
        3'd4: t = {1'b1, 4'b1101};
        3'd5: t = {1'b1, 4'b0101};
        3'd6: t = {1'b1, 4'b1001};
        3'd7: t = {1'b1, 4'b0111};
        default: t = 5'd0;
      endcase
    end else begin
      case (y)
        3'd0: t = {1'b1, 4'b1011};
        3'd1: t = {1'b0, 4'b1001};
        3'd2: t = {1'b0, 4'b0101};
        3'd3: t = {1'b1, 4'b1100};
        3'd4: t = {1'b1, 4'b1101};
        3'd5: t = {1'b0, 4'b1010};
        3'd6: t = {1'b0, 4'b0110};
        3'd7: t = a7 ? {1'b1, 4'b0111} : {1'b1, 4'b1110};
        default: t = 5'd0;
      endcase
    end
    return t;
  endfunction

  function automatic logic [2:0] pop6(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // Returns {rd_after, dout}; an unbalanced sub-block always flips RD.
  function automatic logic [10:0] encode(input logic [7:0] b, input logic k, input logic rd);
    logic [6:0] t6;
    logic [4:0] t4;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd6;
    logic       rd4;
    logic       a7;
    t6  = tab6(b[4:0], k);
    c6  = (rd && t6[6]) ? ~t6[5:0] : t6[5:0];
    rd6 = (pop6(c6) == 3'd3) ? rd : ~rd;
    a7  = (~rd6 & ((b[4:0] == 5'd17) | (b[4:0] == 5'd18) | (b[4:0] == 5'd20))) |
          ( rd6 & ((b[4:0] == 5'd11) | (b[4:0] == 5'd13) | (b[4:0] == 5'd14)));
    t4  = tab4(b[7:5], k, a7);
    c4  = (rd6 && t4[4]) ? ~t4[3:0] : t4[3:0];
    rd4 = (pop6({2'b00, c4}) == 3'd2) ? rd6 : ~rd6;
    return {rd4, c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
  endfunction

  logic [9:0]  dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic        rd_q, rd_d;
  logic        code_err_q, code_err_d;
  logic        advance;
  logic        accept;
  logic        illegal_k;
  logic [7:0]  sym_byte;
  logic [10:0] enc_data;
`ifdef TX_ENC_IDLE_INSERT_EN
  logic [10:0] enc_idle;
  assign enc_idle = encode(IDLE_K, 1'b1, rd_q);
`endif

  assign advance    = dout_ready | ~dout_valid_q;
  assign din_ready  = advance;
  assign accept     = din_valid & advance;
  assign illegal_k  = k_in & ~k_legal(din);
  assign sym_byte   = illegal_k ? IDLE_K : din;
  assign enc_data   = encode(sym_byte, k_in, rd_q);

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign rd_out     = rd_q;
  assign code_err   = code_err_q;

  // Next state of the output register and running disparity
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    rd_d         = rd_q;
    code_err_d   = code_err_q;
    if (accept) begin
      dout_d       = enc_data[9:0];
      rd_d         = enc_data[10];
      dout_valid_d = 1'b1;
      code_err_d   = illegal_k;
    end else if (advance) begin
`ifdef TX_ENC_IDLE_INSERT_EN
      dout_d       = enc_idle[9:0];
      rd_d         = enc_idle[10];
      dout_valid_d = 1'b1;
      code_err_d   = 1'b0;
`else
      dout_valid_d = 1'b0;
      code_err_d   = 1'b0;
`endif
    end else begin
      dout_valid_d = dout_valid_q;
    end
  end

  // Output register and RD state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= 10'h000;
      dout_valid_q <= 1'b0;
      rd_q         <= 1'b0;
      code_err_q   <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      rd_q         <= rd_d;
      code_err_q   <= code_err_d;
    end
  end

endmodule

// File: tb/tb_tx_enc_8b10b.sv
// Scoreboard bench for tx_enc_8b10b: driver pushes expected symbols, monitor pops on every valid output.
module tb_tx_enc_8b10b;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       k_in = 1'b0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [9:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       rd_out;
  logic       code_err;

  always #5 clk = ~clk;

  tx_enc_8b10b #(.IDLE_K(8'hBC)) dut (
    .clk(clk), .rst(rst), .din(din), .k_in(k_in), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .rd_out(rd_out), .code_err(code_err)
  );

  // Clause 36 tables, both disparity columns, written a..i / f..j with the first bit in the MSB
  logic [5:0] t6n [32];
  logic [5:0] t6p [32];
  logic [3:0] t4dn [8];
  logic [3:0] t4dp [8];
  logic [3:0] t4kn [8];
  logic [3:0] t4kp [8];
  logic [7:0] k_list [12];

  logic [11:0] sb [$];   // {rd, code_err, dout}
  logic        m_rd;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] rev10(input logic [9:0] s);
    logic [9:0] d;
    for (int i = 0; i < 10; i++) d[i] = s[9-i];
    return d;
  endfunction

  function automatic logic [11:0] model(input logic [7:0] b, input logic k, input logic rd_in);
    logic [7:0] sym;
    logic       err, rd, legal;
    logic [5:0] c6;
    logic [3:0] c4;
    int         x, y;
    sym = b;
    err = 1'b0;
    if (k) begin
      legal = 1'b0;
      for (int i = 0; i < 12; i++) if (k_list[i] == b) legal = 1'b1;
      if (!legal) begin
        sym = 8'hBC;
        err = 1'b1;
      end
    end
    x  = int'(sym[4:0]);
    y  = int'(sym[7:5]);
    rd = rd_in;
    if (k && x == 28) c6 = rd ? 6'b110000 : 6'b001111;
    else              c6 = rd ? t6p[x] : t6n[x];
    if ($countones(c6) > 3) rd = 1'b1;
    else if ($countones(c6) < 3) rd = 1'b0;
    if (k) c4 = rd ? t4kp[y] : t4kn[y];
    else if (y == 7 && ((!rd && (x == 17 || x == 18 || x == 20)) ||
                        ( rd && (x == 11 || x == 13 || x == 14))))
      c4 = rd ? 4'b1000 : 4'b0111;
    else c4 = rd ? t4dp[y] : t4dn[y];
    if ($countones(c4) > 2) rd = 1'b1;
    else if ($countones(c4) < 2) rd = 1'b0;
    return {rd, err, rev10({c6, c4})};
  endfunction

  task automatic cycle(input logic [7:0] b, input logic k, input logic v, input logic r,
                       input logic rs, input logic use_exp, input logic [9:0] exp_s,
                       input logic exp_rd, input logic exp_err);
    logic       exp_ready;
    logic [11:0] e;
    @(negedge clk);
    din = b; k_in = k; din_valid = v; dout_ready = r; rst = rs;
    if (rs) begin
      sb.delete();
      m_rd = 1'b0;
    end
    #3;
    exp_ready = r | (sb.size() == 0);
    chk("din_ready", 32'(din_ready), 32'(exp_ready));
    if (!rs) begin
      if (v && exp_ready) begin
        if (use_exp) e = {exp_rd, exp_err, rev10(exp_s)};
        else         e = model(b, k, m_rd);
        m_rd = e[11];
        sb.push_back(e);
      end else if (exp_ready) begin
`ifdef TX_ENC_IDLE_INSERT_EN
        e = model(8'hBC, 1'b1, m_rd);
        m_rd = e[11];
        sb.push_back(e);
`endif
      end
    end
  endtask

  task automatic dcyc(input logic [7:0] b, input logic k, input logic [9:0] exp_s,
                      input logic exp_rd, input logic exp_err);
    cycle(b, k, 1'b1, 1'b1, 1'b0, 1'b1, exp_s, exp_rd, exp_err);
  endtask

  task automatic ncyc(input logic [7:0] b, input logic k, input logic v, input logic r,
                      input logic rs);
    cycle(b, k, v, r, rs, 1'b0, 10'd0, 1'b0, 1'b0);
  endtask

  // Monitor: whatever is presented must be the scoreboard head; pop when the serializer takes it
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        chk("reset_state", 32'({dout_valid, rd_out, code_err, dout}), 32'd0);
      end else begin
        chk("dout_valid", 32'(dout_valid), 32'(sb.size() != 0));
        if (dout_valid && sb.size() != 0) begin
          chk("dout", 32'(dout), 32'(sb[0][9:0]));
          chk("rd_out", 32'(rd_out), 32'(sb[0][11]));
          chk("code_err", 32'(code_err), 32'(sb[0][10]));
          if (dout_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic       k;
    t6n = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
            6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
            6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
            6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    t6p = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
            6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
            6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
            6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    t4dn = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    t4dp = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    t4kn = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    t4kp = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    k_list = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
               8'hF7, 8'hFB, 8'hFD, 8'hFE};
    m_rd = 1'b0;

    repeat (3) ncyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // Known code groups, abcdei fghj
    dcyc(8'h00, 1'b0, 10'b100111_0100, 1'b0, 1'b0);  // D0.0 at RD-
    dcyc(8'h03, 1'b0, 10'b110001_1011, 1'b1, 1'b0);  // D3.0 at RD- -> RD+
    dcyc(8'h00, 1'b0, 10'b011000_1011, 1'b1, 1'b0);  // D0.0 at RD+
    dcyc(8'hB5, 1'b0, 10'b101010_1010, 1'b1, 1'b0);  // D21.5 at RD+
    dcyc(8'hEB, 1'b0, 10'b110100_1000, 1'b0, 1'b0);  // D11.7 at RD+ uses A7
    dcyc(8'hB5, 1'b0, 10'b101010_1010, 1'b0, 1'b0);  // D21.5 at RD-
    dcyc(8'hF1, 1'b0, 10'b100011_0111, 1'b1, 1'b0);  // D17.7 at RD- uses A7
    dcyc(8'h00, 1'b1, 10'b110000_0101, 1'b0, 1'b1);  // illegal K -> K28.5 at RD+
    dcyc(8'hBC, 1'b1, 10'b001111_1010, 1'b1, 1'b0);  // K28.5 at RD-
    dcyc(8'hBC, 1'b1, 10'b110000_0101, 1'b0, 1'b0);  // K28.5 at RD+
    dcyc(8'hF7, 1'b1, 10'b111010_1000, 1'b0, 1'b0);  // K23.7 at RD-
    dcyc(8'hFC, 1'b1, 10'b001111_1000, 1'b0, 1'b0);  // K28.7 at RD-

    // Back-pressure: symbol must hold, input must stall
    ncyc(8'h4A, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) ncyc(8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
    ncyc(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
    ncyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset during a hold discards the pending symbol and restarts at RD-
    ncyc(8'hBC, 1'b1, 1'b1, 1'b1, 1'b0);
    ncyc(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    ncyc(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    ncyc(8'h11, 1'b0, 1'b1, 1'b0, 1'b1);
    ncyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    dcyc(8'h00, 1'b0, 10'b100111_0100, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      b = 8'($urandom);
      k = ($urandom_range(0, 3) == 0);
      if (k && $urandom_range(0, 1) == 1) b = k_list[$urandom_range(0, 11)];
      ncyc(b, k, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7), 1'b0);
    end

`ifdef TX_ENC_IDLE_INSERT_EN
    repeat (6) ncyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    repeat (3) ncyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
`ifndef TX_ENC_IDLE_INSERT_EN
    chk("drain_empty", 32'(sb.size()), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
